// File: rtl/ppu_out_buffer.sv
// PPU output FIFO draining int8 vectors to the activation SRAM write port, one row per cycle.
// Optional build macro OBUF_OVF_CNT_EN adds a saturating dropped-vector counter o_drop_cnt.
`ifndef ARRAY_COL
`define ARRAY_COL 4
`endif

module ppu_out_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic [ADDR_W-1:0]          cfg_base_addr,
  input  logic [ADDR_W-1:0]          cfg_num_rows,
  input  logic                       i_valid,
  input  logic [`ARRAY_COL*8-1:0]    i_data_vec,
  output logic                       o_wr_en,
  input  logic                       i_wr_ready,
  output logic [ADDR_W-1:0]          o_wr_addr,
  output logic [`ARRAY_COL*8-1:0]    o_wr_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_overflow,
  output logic [$clog2(DEPTH):0]     o_level
`ifdef OBUF_OVF_CNT_EN
  ,
  output logic [15:0]                o_drop_cnt
`endif
);

  localparam int DW = `ARRAY_COL * 8;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_rows;
  logic [ADDR_W-1:0] accepted;
  logic [ADDR_W-1:0] written_idx;
  logic              overflow;

  logic [PW:0]       wptr;
  logic [PW:0]       rptr;
  logic [PW:0]       level;
  logic [PW-1:0]     widx;
  logic [PW-1:0]     ridx;

  // Each entry carries the row index it was accepted as, so rows dropped
  // while full are skipped in the address sequence rather than shifting it.
  logic [DW-1:0]     mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_tag  [DEPTH];
  logic [ADDR_W-1:0] head_tag;

  logic              full;
  logic              empty;
  logic              start;
  logic              take;
  logic              push;
  logic              drop;
  logic              wr_en;
  logic              pop;

`ifdef OBUF_OVF_CNT_EN
  logic [15:0]       drop_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign widx     = wptr[PW-1:0];
  assign ridx     = rptr[PW-1:0];
  assign level    = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (wptr[PW] != rptr[PW]) && (widx == ridx);
  assign head_tag = mem_tag[ridx];

  assign start = (state == IDLE) && i_start;
  // Full is judged before any same-cycle pop: a full FIFO never takes a push.
  assign take  = (state == RUN) && i_valid && (accepted < num_rows);
  assign push  = take && !full;
  assign drop  = take && full;
  assign wr_en = ((state == RUN) || (state == DRAIN)) && !empty;
  assign pop   = wr_en && i_wr_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = (cfg_num_rows == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (take && ((accepted + ADDR_W'(1)) == num_rows)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (empty || (pop && (level == (PW+1)'(1)))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_addr   <= '0;
      num_rows    <= '0;
      accepted    <= '0;
      written_idx <= '0;
      overflow    <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
    end else begin
      if (start) begin
        base_addr   <= cfg_base_addr;
        num_rows    <= cfg_num_rows;
        accepted    <= '0;
        written_idx <= '0;
        overflow    <= 1'b0;
      end
      if (take) begin
        accepted <= accepted + ADDR_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (push) begin
        wptr <= wptr + (PW+1)'(1);
      end
      if (pop) begin
        rptr        <= rptr + (PW+1)'(1);
        written_idx <= head_tag + ADDR_W'(1);
      end
    end
  end

`ifdef OBUF_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (start) begin
      drop_cnt <= '0;
    end else if (drop) begin
      drop_cnt <= sat_inc16(drop_cnt);
    end
  end

  assign o_drop_cnt = drop_cnt;
`endif

  // Storage carries no reset; validity is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[widx] <= i_data_vec;
      mem_tag[widx]  <= accepted;
    end
  end

  assign o_wr_en    = wr_en;
  assign o_wr_data  = wr_en ? mem_data[ridx] : '0;
  assign o_wr_addr  = base_addr + (wr_en ? head_tag : written_idx);
  assign o_busy     = (state == RUN) || (state == DRAIN);
  assign o_done     = (state == DONE);
  assign o_overflow = overflow;
  assign o_level    = level;

endmodule

// File: tb/tb_ppu_out_buffer.sv
// Directed bench for ppu_out_buffer: ordered writes, stalls, overflow, zero-row and wrapping tiles, control corner cases.
`ifndef ARRAY_COL
`define ARRAY_COL 4
`endif

module tb_ppu_out_buffer;

  localparam int DW = `ARRAY_COL * 8;
  localparam int AW = 16;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [AW-1:0] cfg_base_addr;
  logic [AW-1:0] cfg_num_rows;
  logic          i_valid;
  logic [DW-1:0] i_data_vec;
  logic          o_wr_en;
  logic          i_wr_ready;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_busy;
  logic          o_done;
  logic          o_overflow;
  logic [3:0]    o_level;
`ifdef OBUF_OVF_CNT_EN
  logic [15:0]   o_drop_cnt;
`endif

  ppu_out_buffer #(.DEPTH(8), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_num_rows  (cfg_num_rows),
    .i_valid       (i_valid),
    .i_data_vec    (i_data_vec),
    .o_wr_en       (o_wr_en),
    .i_wr_ready    (i_wr_ready),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_overflow    (o_overflow),
    .o_level       (o_level)
`ifdef OBUF_OVF_CNT_EN
    ,
    .o_drop_cnt    (o_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int            cyc = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            last_wr_cyc = 0;
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  int            log_cyc[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (o_wr_en && i_wr_ready) begin
      log_addr.push_back(o_wr_addr);
      log_data.push_back(o_wr_data);
      log_cyc.push_back(cyc);
      last_wr_cyc = cyc;
    end
    if (o_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] vec(input logic [7:0] b);
    return {`ARRAY_COL{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic start_tile(input logic [AW-1:0] base, input logic [AW-1:0] rows);
    cfg_base_addr = base;
    cfg_num_rows  = rows;
    i_start       = 1'b1;
    tick();
    i_start       = 1'b0;
  endtask

  task automatic push_vec(input logic [7:0] b);
    i_valid    = 1'b1;
    i_data_vec = vec(b);
    tick();
    i_valid    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    for (int i = 0; i < 100 && done_cnt == d0; i++) tick();
    check({tag, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
    tick();
    tick();
    check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_writes(input string tag, input logic [AW-1:0] base, input logic [7:0] b0, input int n);
    check({tag, "_nwr"}, 64'(log_addr.size()), 64'(n));
    for (int i = 0; i < n && i < log_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(log_addr[i]), 64'(AW'(base + AW'(i))));
      check($sformatf("%s_data%0d", tag, i), 64'(log_data[i]), 64'(vec(8'(b0 + 8'(i)))));
    end
  endtask

  initial begin
    int d0;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;

    rst_n = 1'b1; i_start = 1'b0; cfg_base_addr = '0; cfg_num_rows = '0;
    i_valid = 1'b0; i_data_vec = '0; i_wr_ready = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("rst_wr_en", 64'(o_wr_en), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_ovf", 64'(o_overflow), 64'd0);
    check("rst_level", 64'(o_level), 64'd0);
    check("rst_addr", 64'(o_wr_addr), 64'd0);
    check("rst_data", 64'(o_wr_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // T1: back-to-back tile, ready always high
    i_wr_ready = 1'b1;
    clear_log();
    d0 = done_cnt;
    start_tile(16'h0100, 16'd4);
    check("t1_busy", 64'(o_busy), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      push_vec(8'(k));
      check($sformatf("t1_level%0d", k), 64'(o_level), 64'd1);
    end
    wait_done("t1", d0);
    check_writes("t1", 16'h0100, 8'h01, 4);
    check("t1_done_lat", 64'(done_cyc - last_wr_cyc), 64'd1);
    check("t1_ovf", 64'(o_overflow), 64'd0);
    check("t1_idle_busy", 64'(o_busy), 64'd0);

    // T2: fill under backpressure, then drain at full rate
    i_wr_ready = 1'b0;
    clear_log();
    d0 = done_cnt;
    start_tile(16'h0200, 16'd8);
    for (int k = 0; k < 8; k++) push_vec(8'(8'h20 + 8'(k)));
    check("t2_level", 64'(o_level), 64'd8);
    check("t2_ovf", 64'(o_overflow), 64'd0);
    check("t2_wr_en", 64'(o_wr_en), 64'd1);
    hold_addr = o_wr_addr;
    hold_data = o_wr_data;
    check("t2_head_addr", 64'(hold_addr), 64'h0200);
    check("t2_head_data", 64'(hold_data), 64'(vec(8'h20)));
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t2_stall_addr%0d", k), 64'(o_wr_addr), 64'(hold_addr));
      check($sformatf("t2_stall_data%0d", k), 64'(o_wr_data), 64'(hold_data));
    end
    check("t2_no_wr_stalled", 64'(log_addr.size()), 64'd0);
    i_wr_ready = 1'b1;
    wait_done("t2", d0);
    check_writes("t2", 16'h0200, 8'h20, 8);
    if (log_cyc.size() == 8) check("t2_consecutive", 64'(log_cyc[7] - log_cyc[0]), 64'd7);
    check("t2_done_lat", 64'(done_cyc - last_wr_cyc), 64'd1);

    // T3: ten vectors into an eight-deep stalled FIFO
    i_wr_ready = 1'b0;
    clear_log();
    d0 = done_cnt;
    start_tile(16'h0300, 16'd10);
    for (int k = 0; k < 10; k++) push_vec(8'(8'h30 + 8'(k)));
    check("t3_level", 64'(o_level), 64'd8);
    check("t3_ovf", 64'(o_overflow), 64'd1);
`ifdef OBUF_OVF_CNT_EN
    check("t3_drop_cnt", 64'(o_drop_cnt), 64'd2);
`endif
    i_wr_ready = 1'b1;
    wait_done("t3", d0);
    check_writes("t3", 16'h0300, 8'h30, 8);
    check("t3_ovf_sticky", 64'(o_overflow), 64'd1);

    // T4a: zero-row tile; start also clears the sticky overflow
    clear_log();
    d0 = done_cnt;
    start_tile(16'h0400, 16'd0);
    check("t4_zero_done", 64'(o_done), 64'd1);
    check("t4_zero_busy", 64'(o_busy), 64'd0);
    check("t4_ovf_cleared", 64'(o_overflow), 64'd0);
`ifdef OBUF_OVF_CNT_EN
    check("t4_drop_cleared", 64'(o_drop_cnt), 64'd0);
`endif
    tick();
    check("t4_zero_done_end", 64'(o_done), 64'd0);
    check("t4_zero_nwr", 64'(log_addr.size()), 64'd0);
    check("t4_zero_cnt", 64'(done_cnt - d0), 64'd1);

    // T4b: address wrap across 0xFFFF
    clear_log();
    d0 = done_cnt;
    start_tile(16'hFFFE, 16'd3);
    for (int k = 0; k < 3; k++) push_vec(8'(8'h40 + 8'(k)));
    wait_done("t4w", d0);
    check_writes("t4w", 16'hFFFE, 8'h40, 3);

    // T5a: a second start while running must not re-latch the config
    clear_log();
    d0 = done_cnt;
    start_tile(16'h0500, 16'd2);
    push_vec(8'h50);
    start_tile(16'h0600, 16'd5);
    push_vec(8'h51);
    wait_done("t5s", d0);
    check_writes("t5s", 16'h0500, 8'h50, 2);

    // T5b: valid while idle is ignored
    clear_log();
    i_valid = 1'b1;
    i_data_vec = vec(8'h66);
    tick();
    tick();
    tick();
    check("t5i_wr_en", 64'(o_wr_en), 64'd0);
    check("t5i_level", 64'(o_level), 64'd0);
    check("t5i_ovf", 64'(o_overflow), 64'd0);
    i_valid = 1'b0;
    tick();
    check("t5i_nwr", 64'(log_addr.size()), 64'd0);

    // T5c: asynchronous reset mid-tile
    i_wr_ready = 1'b0;
    d0 = done_cnt;
    start_tile(16'h0700, 16'd4);
    push_vec(8'h70);
    push_vec(8'h71);
    check("t5r_pre_level", 64'(o_level), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t5r_busy", 64'(o_busy), 64'd0);
    check("t5r_level", 64'(o_level), 64'd0);
    check("t5r_wr_en", 64'(o_wr_en), 64'd0);
    check("t5r_addr", 64'(o_wr_addr), 64'd0);
    check("t5r_data", 64'(o_wr_data), 64'd0);
    tick();
    rst_n = 1'b1;
    i_wr_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("t5r_no_done", 64'(done_cnt - d0), 64'd0);
    check("t5r_idle_busy", 64'(o_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
